pipe_skid_stage: RTL and testbench
==================================

Name: pipe_skid_stage

Overview:
- Parametrised elastic pipeline stage register for the core pipeline (IF/ID, ID/EX, EX/MEM, MEM/WB). It generalises the fixed-field stall register.
- Carries a DW-bit payload and a CW-bit control bundle under a valid/ready handshake.
- A two-entry skid buffer keeps in_ready fully registered, so there is no combinational ready path between stages.
- A synchronous flush kills in-flight beats and forces control bits to zero (bubble).

Parameters:
DW, 32, payload width (PC+4, ALU result, PC+imm, rs1 data, etc. concatenated by the instantiating stage)
CW, 16, control bundle width (regWrite, memRead, memWrite, rd, fnc3, ...); zeroed on bubble or flush
CNT_W, 16, stall counter width (used only with PIPE_STAGE_STATS_EN)

Ports:
clk  input  1  clock, rising edge
rst  input  1  asynchronous, active-low reset
flush  input  1  synchronous kill of all held beats
in_valid  input  1  upstream beat valid
in_ready  output  1  stage can accept a beat (registered)
in_data  input  DW  upstream payload
in_ctrl  input  CW  upstream control bundle
out_valid  output  1  downstream beat valid (registered)
out_ready  input  1  downstream accepts beat
out_data  output  DW  payload to next stage (registered)
out_ctrl  output  CW  control to next stage (registered); 0 when out_valid=0
stall_cnt  output  CNT_W  backpressure cycle count (only with PIPE_STAGE_STATS_EN)

Behaviour:
- Reset (rst=0, async): state EMPTY; out_valid=0; out_data=0; out_ctrl=0; skid regs=0; in_ready=1; stall_cnt=0.
- Handshake rules:
  - push = in_valid & in_ready; pop = out_valid & out_ready.
  - Payload and ctrl are sampled only on push.
  - out_* must be held stable while out_valid & !out_ready.
- Registers: main (drives out_*) and skid.
- State machine, evaluated at posedge when flush=0:
  - EMPTY (in_ready=1, out_valid=0):
    - push -> BUSY, main<=in.
    - else stay.
  - BUSY (in_ready=1, out_valid=1):
    - push&pop -> BUSY, main<=in.
    - push&!pop -> FULL, skid<=in.
    - !push&pop -> EMPTY.
    - else hold.
  - FULL (in_ready=0, out_valid=1):
    - pop -> BUSY, main<=skid, skid ctrl<=0.
    - else hold.
- in_ready is a registered function of next state: 1 iff next state != FULL.
- Latency: 1 cycle from push to out_valid in EMPTY/BUSY. Throughput 1 beat/cycle with out_ready=1. No bubbles inserted while streaming.
- Ordering: strict FIFO; the skid beat is always younger than main.
- Bubble rule: whenever an entry is empty, its ctrl is 0. Hence out_ctrl=0 whenever out_valid=0, and a downstream stage may ignore out_valid for write-enable gating.
- flush=1 (priority over push/pop):
  - Next state EMPTY, out_valid=0, in_ready=1.
  - main ctrl and skid ctrl are set to 0; data registers hold their value.
  - A beat pushed in the flush cycle is discarded. The upstream still sees it as accepted.
  - A pop coinciding with flush completes normally for the downstream, since it sampled out_* that cycle.
- Reset mid-operation: asynchronously returns to reset values regardless of state or flush.
- Widths: no arithmetic on payload; DW and CW ≥ 1.

Optional Feature:
- Macro: PIPE_STAGE_STATS_EN.
- Defined:
  - Adds port stall_cnt[CNT_W-1:0].
  - Increments each cycle with out_valid=1 & out_ready=0; saturates at all-ones.
  - Cleared only by rst; unaffected by flush.
- Undefined: stall_cnt port and its counter logic are absent. All other behaviour is identical.

Test Plan:
- Reset: assert rst=0 with in_valid=1, in_ctrl=0xFFFF -> out_valid=0, out_ctrl=0x0000, in_ready=1. After release with in_valid=0: no output change.
- Streaming: out_ready=1, push data 0x1,0x2,0x3 on consecutive cycles -> out_data 0x1,0x2,0x3 on the next three cycles, out_valid continuously 1, in_ready never 0.
- Backpressure/skid: out_ready=0, push A=0xA5 then B=0x5A -> in_ready=0 after second push, out_data=0xA5 held. Raise out_ready -> A popped, then B next cycle, in_ready=1 the cycle after A's pop, no loss or duplication.
- Flush in FULL: hold A,B, assert flush with in_valid=1, data 0xC3 -> next cycle out_valid=0, out_ctrl=0, in_ready=1. Neither A, B nor 0xC3 ever appears.
- Simultaneous push/pop in BUSY: main=0x10, push 0x20 with out_ready=1 -> next cycle out_data=0x20, state BUSY, in_ready=1.
- Stats (PIPE_STAGE_STATS_EN, CNT_W=4): out_valid=1, out_ready=0 for 20 cycles -> stall_cnt=15 (saturated). Flush -> stays 15. rst -> 0.

Source files
------------

// File: rtl/pipe_skid_stage.sv
// Elastic pipeline stage: registered main + skid entry, in_ready fully registered.
// Optional backpressure statistics counter: define PIPE_STAGE_STATS_EN.
//
// state | meaning
// EMPTY | no beat held; in_ready=1, out_valid=0
// BUSY  | main holds a beat; in_ready=1, out_valid=1
// FULL  | main and skid hold beats; in_ready=0, out_valid=1
module pipe_skid_stage #(
  parameter int DW    = 32,
  parameter int CW    = 16,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [DW-1:0]    in_data,
  input  logic [CW-1:0]    in_ctrl,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [DW-1:0]    out_data,
  output logic [CW-1:0]    out_ctrl
`ifdef PIPE_STAGE_STATS_EN
  ,
  output logic [CNT_W-1:0] stall_cnt
`endif
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    BUSY  = 2'd1,
    FULL  = 2'd2
  } state_t;

  state_t          state;
  logic [DW-1:0]   skid_data;
  logic [CW-1:0]   skid_ctrl;
  logic            push;
  logic            pop;

  assign push = in_valid & in_ready;
  assign pop  = out_valid & out_ready;

  // ctrl of an empty entry is always forced to zero so downstream sees a bubble
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= EMPTY;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_ctrl  <= '0;
      skid_data <= '0;
      skid_ctrl <= '0;
    end else if (flush) begin
      state     <= EMPTY;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      out_ctrl  <= '0;
      skid_ctrl <= '0;
    end else begin
      case (state)
        EMPTY: begin
          if (push) begin
            state     <= BUSY;
            out_valid <= 1'b1;
            out_data  <= in_data;
            out_ctrl  <= in_ctrl;
          end
        end
        BUSY: begin
          if (push && pop) begin
            out_data <= in_data;
            out_ctrl <= in_ctrl;
          end else if (push) begin
            state     <= FULL;
            in_ready  <= 1'b0;
            skid_data <= in_data;
            skid_ctrl <= in_ctrl;
          end else if (pop) begin
            state     <= EMPTY;
            out_valid <= 1'b0;
            out_ctrl  <= '0;
          end
        end
        FULL: begin
          if (pop) begin
            state     <= BUSY;
            in_ready  <= 1'b1;
            out_data  <= skid_data;
            out_ctrl  <= skid_ctrl;
            skid_ctrl <= '0;
          end
        end
        default: begin
          state     <= EMPTY;
          in_ready  <= 1'b1;
          out_valid <= 1'b0;
          out_ctrl  <= '0;
          skid_ctrl <= '0;
        end
      endcase
    end
  end

`ifdef PIPE_STAGE_STATS_EN
  // saturating count of stalled cycles; only reset clears it
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stall_cnt <= '0;
    end else if (out_valid && !out_ready && (stall_cnt != '1)) begin
      stall_cnt <= stall_cnt + CNT_W'(1);
    end
  end
`endif

endmodule

// File: tb/tb_pipe_skid_stage.sv
// Self-checking bench for pipe_skid_stage with a push/pop scoreboard.
// Stats checks are built when PIPE_STAGE_STATS_EN is defined.
module tb_pipe_skid_stage;
  localparam int DW    = 32;
  localparam int CW    = 16;
  localparam int CNT_W = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          flush;
  logic          in_valid;
  logic          in_ready;
  logic [DW-1:0] in_data;
  logic [CW-1:0] in_ctrl;
  logic          out_valid;
  logic          out_ready;
  logic [DW-1:0] out_data;
  logic [CW-1:0] out_ctrl;
`ifdef PIPE_STAGE_STATS_EN
  logic [CNT_W-1:0] stall_cnt;
`endif

  int total = 0;
  int bad   = 0;
  logic [DW+CW-1:0] exp_q[$];
  logic [DW+CW-1:0] got_q[$];

  always #5 clk = ~clk;

  pipe_skid_stage #(.DW(DW), .CW(CW), .CNT_W(CNT_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_ctrl   (in_ctrl),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_ctrl  (out_ctrl)
`ifdef PIPE_STAGE_STATS_EN
    ,
    .stall_cnt (stall_cnt)
`endif
  );

  // records handshakes seen at the coming edge, then advances one cycle
  task automatic tick();
    logic push;
    logic pop;
    int   outstanding;
    push = in_valid & in_ready;
    pop  = out_valid & out_ready;
    if (rst) begin
      if (pop) got_q.push_back({out_data, out_ctrl});
      if (flush) begin
        outstanding = exp_q.size() - got_q.size();
        for (int i = 0; i < outstanding; i++) exp_q.delete(exp_q.size() - 1);
      end else if (push) begin
        exp_q.push_back({in_data, in_ctrl});
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [DW-1:0] d, input logic [CW-1:0] c);
    in_valid = v;
    in_data  = d;
    in_ctrl  = c;
  endtask

  task automatic test_reset();
    rst = 1'b0; flush = 1'b0; out_ready = 1'b0;
    drive(1'b1, 32'hDEAD_BEEF, 16'hFFFF);
    repeat (2) @(posedge clk);
    #1;
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
    total++; if (out_ctrl !== 16'h0000) begin bad++; $display("FAIL reset_out_ctrl: got %h want 0000", out_ctrl); end
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
    total++; if (out_data !== '0) begin bad++; $display("FAIL reset_out_data: got %h want 0", out_data); end
    drive(1'b0, 32'h0, 16'h0);
    exp_q.delete(); got_q.delete();
    #2 rst = 1'b1;
    repeat (3) tick();
    total++; if (out_valid !== 1'b0 || out_ctrl !== 16'h0 || out_data !== '0) begin
      bad++; $display("FAIL reset_release: got v=%b c=%h d=%h want 0/0/0", out_valid, out_ctrl, out_data);
    end
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL reset_release_ready: got %b want 1", in_ready); end
  endtask

  task automatic test_stream();
    logic [DW+CW-1:0] ev, gv;
    out_ready = 1'b1;
    for (int i = 1; i <= 3; i++) begin
      drive(1'b1, DW'(i), CW'(16'h0100 + i));
      tick();
      total++; if (out_valid !== 1'b1 || out_data !== DW'(i) || out_ctrl !== CW'(16'h0100 + i)) begin
        bad++; $display("FAIL stream_beat%0d: got v=%b d=%h c=%h want 1/%h/%h", i, out_valid, out_data, out_ctrl, i, 16'h0100 + i);
      end
      total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL stream_ready%0d: got %b want 1", i, in_ready); end
    end
    drive(1'b0, '0, '0);
    tick();
    total++; if (out_valid !== 1'b0 || out_ctrl !== '0) begin
      bad++; $display("FAIL stream_end: got v=%b c=%h want 0/0", out_valid, out_ctrl);
    end
    while (got_q.size() > 0) begin
      gv = got_q.pop_front(); total++;
      if (exp_q.size() == 0) begin bad++; $display("FAIL stream_extra: got %h want none", gv); end
      else begin ev = exp_q.pop_front(); if (gv !== ev) begin bad++; $display("FAIL stream_order: got %h want %h", gv, ev); end end
    end
    total++; if (exp_q.size() != 0) begin bad++; $display("FAIL stream_lost: got %0d left want 0", exp_q.size()); end
  endtask

  task automatic test_skid();
    logic [DW+CW-1:0] ev, gv;
    out_ready = 1'b0;
    drive(1'b1, 32'hA5, 16'h00A5);
    tick();
    total++; if (in_ready !== 1'b1 || out_data !== 32'hA5) begin
      bad++; $display("FAIL skid_first: got r=%b d=%h want 1/a5", in_ready, out_data);
    end
    drive(1'b1, 32'h5A, 16'h005A);
    tick();
    total++; if (in_ready !== 1'b0 || out_valid !== 1'b1 || out_data !== 32'hA5) begin
      bad++; $display("FAIL skid_full: got r=%b v=%b d=%h want 0/1/a5", in_ready, out_valid, out_data);
    end
    drive(1'b1, 32'hEE, 16'h00EE);
    repeat (2) tick();
    total++; if (in_ready !== 1'b0 || out_data !== 32'hA5 || out_ctrl !== 16'h00A5) begin
      bad++; $display("FAIL skid_hold: got r=%b d=%h c=%h want 0/a5/00a5", in_ready, out_data, out_ctrl);
    end
    drive(1'b0, '0, '0);
    out_ready = 1'b1;
    tick();
    total++; if (out_valid !== 1'b1 || out_data !== 32'h5A || out_ctrl !== 16'h005A || in_ready !== 1'b1) begin
      bad++; $display("FAIL skid_popA: got v=%b d=%h c=%h r=%b want 1/5a/005a/1", out_valid, out_data, out_ctrl, in_ready);
    end
    tick();
    total++; if (out_valid !== 1'b0 || out_ctrl !== '0) begin
      bad++; $display("FAIL skid_popB: got v=%b c=%h want 0/0", out_valid, out_ctrl);
    end
    while (got_q.size() > 0) begin
      gv = got_q.pop_front(); total++;
      if (exp_q.size() == 0) begin bad++; $display("FAIL skid_extra: got %h want none", gv); end
      else begin ev = exp_q.pop_front(); if (gv !== ev) begin bad++; $display("FAIL skid_order: got %h want %h", gv, ev); end end
    end
    total++; if (exp_q.size() != 0) begin bad++; $display("FAIL skid_lost: got %0d left want 0", exp_q.size()); end
  endtask

  task automatic test_flush();
    logic [DW+CW-1:0] ev, gv;
    out_ready = 1'b0;
    drive(1'b1, 32'hA5, 16'h0A0A);
    tick();
    drive(1'b1, 32'h5A, 16'h0505);
    tick();
    drive(1'b1, 32'hC3, 16'h00C3);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    drive(1'b0, '0, '0);
    total++; if (out_valid !== 1'b0 || out_ctrl !== '0 || in_ready !== 1'b1) begin
      bad++; $display("FAIL flush_full: got v=%b c=%h r=%b want 0/0/1", out_valid, out_ctrl, in_ready);
    end
    total++; if (out_data !== 32'hA5) begin bad++; $display("FAIL flush_data_hold: got %h want a5", out_data); end
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL flush_ghost%0d: got v=%b d=%h want v=0", i, out_valid, out_data); end
    end
    // flush in BUSY with a coincident push (discarded) and pop (completes)
    drive(1'b1, 32'h77, 16'h0077);
    tick();
    drive(1'b1, 32'h88, 16'h0088);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    drive(1'b0, '0, '0);
    total++; if (out_valid !== 1'b0 || out_ctrl !== '0 || in_ready !== 1'b1) begin
      bad++; $display("FAIL flush_busy: got v=%b c=%h r=%b want 0/0/1", out_valid, out_ctrl, in_ready);
    end
    tick();
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL flush_discard: got v=%b d=%h want v=0", out_valid, out_data); end
    while (got_q.size() > 0) begin
      gv = got_q.pop_front(); total++;
      if (exp_q.size() == 0) begin bad++; $display("FAIL flush_extra: got %h want none", gv); end
      else begin ev = exp_q.pop_front(); if (gv !== ev) begin bad++; $display("FAIL flush_order: got %h want %h", gv, ev); end end
    end
    total++; if (exp_q.size() != 0) begin bad++; $display("FAIL flush_lost: got %0d left want 0", exp_q.size()); end
  endtask

  task automatic test_back_to_back();
    logic [DW+CW-1:0] ev, gv;
    out_ready = 1'b1;
    drive(1'b1, 32'h10, 16'h0010);
    tick();
    total++; if (out_data !== 32'h10) begin bad++; $display("FAIL b2b_first: got %h want 10", out_data); end
    drive(1'b1, 32'h20, 16'h0020);
    tick();
    total++; if (out_data !== 32'h20 || out_valid !== 1'b1 || in_ready !== 1'b1) begin
      bad++; $display("FAIL b2b_swap: got d=%h v=%b r=%b want 20/1/1", out_data, out_valid, in_ready);
    end
    drive(1'b0, '0, '0);
    tick();
    while (got_q.size() > 0) begin
      gv = got_q.pop_front(); total++;
      if (exp_q.size() == 0) begin bad++; $display("FAIL b2b_extra: got %h want none", gv); end
      else begin ev = exp_q.pop_front(); if (gv !== ev) begin bad++; $display("FAIL b2b_order: got %h want %h", gv, ev); end end
    end
    total++; if (exp_q.size() != 0) begin bad++; $display("FAIL b2b_lost: got %0d left want 0", exp_q.size()); end
  endtask

  task automatic test_random();
    logic [DW+CW-1:0] ev, gv, held_v;
    logic held;
    for (int n = 0; n < 400; n++) begin
      drive(1'($urandom_range(0, 1)), DW'($urandom), CW'($urandom));
      out_ready = ($urandom_range(0, 2) != 0);
      flush = ($urandom_range(0, 24) == 0);
      held = out_valid & ~out_ready & ~flush;
      held_v = {out_data, out_ctrl};
      tick();
      if (held) begin
        total++; if (out_valid !== 1'b1 || {out_data, out_ctrl} !== held_v) begin
          bad++; $display("FAIL rand_stable@%0d: got v=%b %h want 1/%h", n, out_valid, {out_data, out_ctrl}, held_v);
        end
      end
      if (out_valid === 1'b0) begin
        total++; if (out_ctrl !== '0) begin bad++; $display("FAIL rand_bubble@%0d: got %h want 0", n, out_ctrl); end
      end
      while (got_q.size() > 0) begin
        gv = got_q.pop_front(); total++;
        if (exp_q.size() == 0) begin bad++; $display("FAIL rand_extra@%0d: got %h want none", n, gv); end
        else begin ev = exp_q.pop_front(); if (gv !== ev) begin bad++; $display("FAIL rand_order@%0d: got %h want %h", n, gv, ev); end end
      end
      total++; if (in_ready !== (exp_q.size() < 2) || out_valid !== (exp_q.size() > 0)) begin
        bad++; $display("FAIL rand_occ@%0d: got r=%b v=%b want occupancy %0d", n, in_ready, out_valid, exp_q.size());
      end
    end
    flush = 1'b0;
    drive(1'b0, '0, '0);
    out_ready = 1'b1;
    repeat (3) tick();
    while (got_q.size() > 0) begin
      gv = got_q.pop_front(); total++;
      if (exp_q.size() == 0) begin bad++; $display("FAIL rand_extra_end: got %h want none", gv); end
      else begin ev = exp_q.pop_front(); if (gv !== ev) begin bad++; $display("FAIL rand_order_end: got %h want %h", gv, ev); end end
    end
    total++; if (exp_q.size() != 0) begin bad++; $display("FAIL rand_lost: got %0d left want 0", exp_q.size()); end
  endtask

  task automatic test_async_reset();
    out_ready = 1'b0;
    drive(1'b1, 32'h11, 16'h0011);
    repeat (2) tick();
    drive(1'b0, '0, '0);
    #2 rst = 1'b0;
    #1;
    total++; if (out_valid !== 1'b0 || in_ready !== 1'b1 || out_ctrl !== '0 || out_data !== '0) begin
      bad++; $display("FAIL async_reset: got v=%b r=%b c=%h d=%h want 0/1/0/0", out_valid, in_ready, out_ctrl, out_data);
    end
    exp_q.delete(); got_q.delete();
    #3 rst = 1'b1;
    tick();
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL async_release: got v=%b want 0", out_valid); end
  endtask

`ifdef PIPE_STAGE_STATS_EN
  task automatic test_stats();
    rst = 1'b0;
    #1;
    total++; if (stall_cnt !== '0) begin bad++; $display("FAIL stats_reset: got %0d want 0", stall_cnt); end
    exp_q.delete(); got_q.delete();
    #3 rst = 1'b1;
    out_ready = 1'b0;
    drive(1'b1, 32'h33, 16'h0033);
    tick();
    drive(1'b0, '0, '0);
    total++; if (stall_cnt !== 4'd0) begin bad++; $display("FAIL stats_start: got %0d want 0", stall_cnt); end
    repeat (3) tick();
    total++; if (stall_cnt !== 4'd3) begin bad++; $display("FAIL stats_three: got %0d want 3", stall_cnt); end
    repeat (17) tick();
    total++; if (stall_cnt !== 4'd15) begin bad++; $display("FAIL stats_sat: got %0d want 15", stall_cnt); end
    flush = 1'b1;
    tick();
    flush = 1'b0;
    tick();
    total++; if (stall_cnt !== 4'd15) begin bad++; $display("FAIL stats_flush: got %0d want 15", stall_cnt); end
    #2 rst = 1'b0;
    #1;
    total++; if (stall_cnt !== 4'd0) begin bad++; $display("FAIL stats_rst: got %0d want 0", stall_cnt); end
    exp_q.delete(); got_q.delete();
    #3 rst = 1'b1;
    tick();
  endtask
`endif

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_stream();
    test_skid();
    test_flush();
    test_back_to_back();
    test_random();
    test_async_reset();
`ifdef PIPE_STAGE_STATS_EN
    test_stats();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
